// File: rtl/kbd_serializer_if.sv
// Signal bundle between a keyboard-side host and the serializer:
// snapshot inputs, enable, and the framed serial outputs.
`timescale 1ns/1ps
interface kbd_serializer_if;
    logic        I_EN;
    logic [63:0] I_MATRIX;
    logic [2:0]  I_SHIFT;
    logic        I_K_RESET;
    logic        O_TX;
    logic        O_NEWFRAME;
    logic        O_BUSY;
    logic        O_DONE;

    modport master (
        output I_EN, I_MATRIX, I_SHIFT, I_K_RESET,
        input  O_TX, O_NEWFRAME, O_BUSY, O_DONE
    );

    modport slave (
        input  I_EN, I_MATRIX, I_SHIFT, I_K_RESET,
        output O_TX, O_NEWFRAME, O_BUSY, O_DONE
    );
endinterface

// File: rtl/kbd_serializer.sv
// Keyboard link transmitter: snapshots the key matrix and flags, then sends a
// sync bit period followed by 72 data bits MSB first and an idle gap.
`timescale 1ns/1ps
module kbd_serializer #(
    parameter int CLK_DIV  = 50,
    parameter int GAP_BITS = 8
) (
    input logic             I_CLK,
    input logic             I_RESET,
    kbd_serializer_if.slave bus
);
    localparam int FRAME_BITS = 72;
    localparam int DW         = $clog2(CLK_DIV);
    localparam int GW         = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
    localparam logic [6:0]    BIT_LAST = 7'd71;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    state_t                  state, state_d;
    logic [DW-1:0]           div_cnt;
    logic [6:0]              bit_cnt;
    logic [GW-1:0]           gap_cnt;
    logic [FRAME_BITS-1:0]   sh_q, snap;
    logic                    tx_q, nf_q, busy_q, done_q;
    logic                    tx_d, nf_d, busy_d, done_d;
    logic                    tick, load, shift, fin;

    // Row 0 goes out first, so it lands in the top byte of the shift register.
    always_comb begin
        snap = '0;
        for (int r = 0; r < 8; r++)
            snap[FRAME_BITS-1-8*r -: 8] = bus.I_MATRIX[8*r +: 8];
        snap[7:0] = {bus.I_SHIFT, bus.I_K_RESET, 4'b0000};
    end

    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        tx_d    = 1'b1;
        nf_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: fin = 1'b1;
            SYNC: begin
                nf_d = 1'b1;
                if (tick) begin
                    state_d = DATA;
                    nf_d    = 1'b0;
                    tx_d    = sh_q[FRAME_BITS-1];
                end
            end
            DATA: begin
                tx_d = sh_q[FRAME_BITS-1];
                // Registered pulse, so raise it one clock early to cover the final clock.
                done_d = (bit_cnt == BIT_LAST) && (div_cnt == DIV_PRE);
                if (tick) begin
                    if (bit_cnt == BIT_LAST) begin
                        tx_d = 1'b1;
                        if (GAP_BITS != 0) state_d = GAP;
                        else               fin     = 1'b1;
                    end else begin
                        tx_d  = sh_q[FRAME_BITS-2];
                        shift = 1'b1;
                    end
                end
            end
            GAP: fin = tick && (gap_cnt == GAP_LAST);
            default: state_d = IDLE;
        endcase
        // Shared frame-boundary decision: idle wait, end of gap, or gapless end of data.
        if (fin) begin
            if (bus.I_EN) begin
                load    = 1'b1;
                state_d = SYNC;
                nf_d    = 1'b1;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sh_q    <= '1;
            tx_q    <= 1'b1;
            nf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            nf_q   <= nf_d;
            busy_q <= busy_d;
            done_q <= done_d;

            if (state == IDLE || state_d != state || tick) div_cnt <= '0;
            else                                            div_cnt <= div_cnt + 1'b1;

            if (state_d != DATA)            bit_cnt <= '0;
            else if (tick && state == DATA) bit_cnt <= bit_cnt + 1'b1;

            if (state_d != GAP)            gap_cnt <= '0;
            else if (tick && state == GAP) gap_cnt <= gap_cnt + 1'b1;

            if (load)       sh_q <= snap;
            else if (shift) sh_q <= {sh_q[FRAME_BITS-2:0], 1'b1};
        end
    end

    assign bus.O_TX       = tx_q;
    assign bus.O_NEWFRAME = nf_q;
    assign bus.O_BUSY     = busy_q;
    assign bus.O_DONE     = done_q;
endmodule

// File: tb/tb_kbd_serializer.sv
// Bench for kbd_serializer: three instances with different divider/gap settings,
// random snapshots, and a serial-stream decoder that scoreboards whole frames.
`timescale 1ns/1ps
module tb_kbd_serializer;
    typedef logic [71:0] frame_t;
    localparam int NI = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NI-1:0]  en  = '0;
    logic [63:0]    mat = '1;
    logic [2:0]     shf = '1;
    logic           kres = 1'b0;
    logic [NI-1:0]  tx_v, nf_v, busy_v, done_v;
    logic [1:0]     act = 2'd0;

    int     checks = 0, errors = 0;
    frame_t exp_q[$];
    bit     tb_end = 1'b0, fin = 1'b0;

    always #5 clk = ~clk;

    function automatic int cd_of(input logic [1:0] g);
        return (g == 2'd0) ? 4 : (g == 2'd1) ? 2 : 50;
    endfunction
    function automatic int gb_of(input logic [1:0] g);
        return (g == 2'd1) ? 0 : 8;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : inst
        kbd_serializer_if bus ();
        assign bus.I_EN      = en[g];
        assign bus.I_MATRIX  = mat;
        assign bus.I_SHIFT   = shf;
        assign bus.I_K_RESET = kres;
        kbd_serializer #(
            .CLK_DIV  (g == 0 ? 4 : (g == 1 ? 2 : 50)),
            .GAP_BITS (g == 1 ? 0 : 8)
        ) dut (
            .I_CLK   (clk),
            .I_RESET (rst),
            .bus     (bus.slave)
        );
        assign tx_v[g]   = bus.O_TX;
        assign nf_v[g]   = bus.O_NEWFRAME;
        assign busy_v[g] = bus.O_BUSY;
        assign done_v[g] = bus.O_DONE;
    end

    wire m_tx   = tx_v[act];
    wire m_nf   = nf_v[act];
    wire m_busy = busy_v[act];
    wire m_done = done_v[act];

    // Reference: list the bits in transmission order, then pack first-sent into the MSB.
    function automatic frame_t model(input logic [63:0] m, input logic [2:0] s, input logic k);
        bit     q[$];
        frame_t f = '0;
        for (int r = 0; r < 8; r++)
            for (int b = 7; b >= 0; b--) q.push_back(m[8*r+b]);
        for (int b = 2; b >= 0; b--) q.push_back(s[b]);
        q.push_back(k);
        repeat (4) q.push_back(1'b0);
        foreach (q[i]) f = {f[70:0], q[i]};
        return f;
    endfunction

    // Stream decoder and scoreboard
    int     cyc = 0, last_rise = 0, data_end = 0, nf_len = 0, wd = 0;
    int     bit_idx = 0, sub = 0;
    bit     have_rise = 0, busy_held = 0, in_data = 0, glitch = 0, done_bad = 0, idle_bad = 0;
    logic   nf_prev = 1'b0, busy_prev = 1'b0;
    frame_t frame, exp_f;

    always @(negedge clk) begin
        int cd, gb;
        cd = cd_of(act);
        gb = gb_of(act);
        if (rst) begin
            checks++;
            if (m_tx !== 1'b1 || m_nf !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: tx=%b nf=%b busy=%b done=%b, want 1 0 0 0", m_tx, m_nf, m_busy, m_done);
            end
            exp_q.delete();
            in_data = 0; have_rise = 0; busy_held = 0; idle_bad = 0; wd = 0;
            nf_prev = 1'b0; busy_prev = 1'b0;
        end else begin
            cyc++;
            if (m_nf && !nf_prev) begin
                checks++;
                if (idle_bad || m_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL sync_start: idle_glitch=%0d busy=%b, want 0 1", idle_bad, m_busy);
                end
                idle_bad = 0;
                if (have_rise && busy_held) begin
                    checks++;
                    if (cyc - last_rise != (73 + gb) * cd) begin
                        errors++;
                        $display("FAIL frame_period: got %0d clocks, want %0d", cyc - last_rise, (73 + gb) * cd);
                    end
                end
                have_rise = 1; last_rise = cyc; busy_held = 1; nf_len = 0;
            end
            if (m_nf) nf_len++;
            if (!m_nf && nf_prev) begin
                checks++;
                if (nf_len != cd) begin
                    errors++;
                    $display("FAIL sync_len: got %0d clocks, want %0d", nf_len, cd);
                end
                in_data = 1; bit_idx = 0; sub = 0; frame = '0; glitch = 0; done_bad = 0;
            end
            if (in_data) begin
                if (sub == 0) frame = {frame[70:0], m_tx};
                else if (m_tx !== frame[0]) glitch = 1;
                if (m_nf !== 1'b0 || m_busy !== 1'b1) glitch = 1;
                if (m_done !== ((bit_idx == 71) && (sub == cd - 1))) done_bad = 1;
                sub++;
                if (sub == cd) begin sub = 0; bit_idx++; end
                if (bit_idx == 72) begin
                    in_data = 0; data_end = cyc; wd = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_data: got %h, want no frame", frame);
                    end else begin
                        exp_f = exp_q.pop_front();
                        if (frame !== exp_f) begin
                            errors++;
                            $display("FAIL frame_data: got %h, want %h", frame, exp_f);
                        end
                    end
                    checks++;
                    if (glitch || done_bad) begin
                        errors++;
                        $display("FAIL bit_timing: glitch=%0d done_misplaced=%0d, want 0 0", glitch, done_bad);
                    end
                end
            end else if (m_tx !== 1'b1 || m_done !== 1'b0) idle_bad = 1;

            if (!m_busy) busy_held = 0;
            if (busy_prev && !m_busy) begin
                checks++;
                if (idle_bad || cyc - data_end != gb * cd + 1) begin
                    errors++;
                    $display("FAIL busy_fall: %0d clocks after data, idle_glitch=%0d, want %0d and 0",
                             cyc - data_end, idle_bad, gb * cd + 1);
                end
                idle_bad = 0;
            end

            if (exp_q.size() != 0) wd++; else wd = 0;
            if (wd > 2 * (75 + gb) * cd + 50) begin
                checks++; errors++;
                $display("FAIL frame_timeout: no frame within %0d clocks, want a frame", wd);
                void'(exp_q.pop_front());
                wd = 0;
            end
            nf_prev = m_nf; busy_prev = m_busy;
        end
        if (tb_end && !fin) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover_frames: got %0d pending, want 0", exp_q.size());
            end
            fin = 1'b1;
        end
    end

    // Stimulus
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input bit use_busy, input logic val, input int lim);
        for (int k = 0; k < lim; k++) begin
            if (((use_busy ? m_busy : m_nf)) === val) return;
            tick();
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic set_inputs(input logic [63:0] m, input logic [2:0] s, input logic k, input bit push);
        mat = m; shf = s; kres = k;
        if (push) exp_q.push_back(model(m, s, k));
    endtask

    task automatic scribble(input logic [63:0] junk);
        mat = junk; shf = ~shf; kres = ~kres;
    endtask

    function automatic int lim_of();
        return (76 + gb_of(act)) * cd_of(act) + 20;
    endfunction

    task automatic pulse_frame(input logic [63:0] m, input logic [2:0] s, input logic k, input logic [63:0] junk);
        set_inputs(m, s, k, 1);
        en[act] = 1'b1; tick(); en[act] = 1'b0;
        wait_until(0, 1'b0, lim_of());
        tick(5);
        scribble(junk);
        wait_until(1, 1'b0, lim_of());
        tick(3);
    endtask

    task automatic held_frames(input int n);
        set_inputs(rnd64(), 3'($urandom), 1'($urandom), 1);
        en[act] = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_until(0, 1'b1, lim_of());
            wait_until(0, 1'b0, lim_of());
            tick(5);
            scribble(rnd64());
            tick(10);
            if (i < n - 1) set_inputs(rnd64(), 3'($urandom), 1'($urandom), 1);
            else           en[act] = 1'b0;
        end
        wait_until(1, 1'b0, lim_of());
        tick(3);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(3);

        act = 2'd0;
        pulse_frame(64'hFFFF_FFFF_FFFF_FFFE, 3'b101, 1'b0, rnd64());
        pulse_frame(rnd64(), 3'($urandom), 1'($urandom), 64'h0);
        pulse_frame(64'h0, 3'b010, 1'b1, rnd64());
        held_frames(4);

        // Reset in the middle of the data bits, restart with enable held
        set_inputs(rnd64(), 3'($urandom), 1'($urandom), 1);
        en[0] = 1'b1; tick(); en[0] = 1'b0;
        wait_until(0, 1'b0, lim_of());
        tick(40);
        rst = 1'b1;
        tick(2);
        en[0] = 1'b1;
        rst = 1'b0;
        set_inputs(rnd64(), 3'($urandom), 1'($urandom), 1);
        wait_until(0, 1'b1, lim_of());
        wait_until(0, 1'b0, lim_of());
        tick(5);
        en[0] = 1'b0;
        wait_until(1, 1'b0, lim_of());
        tick(3);

        act = 2'd1;
        held_frames(4);
        pulse_frame(rnd64(), 3'($urandom), 1'($urandom), rnd64());

        act = 2'd2;
        held_frames(3);

        tb_end = 1'b1;
        for (int k = 0; k < 100 && !fin; k++) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
